// File: rtl/lc_cfg_sequencer_if.sv
// Host write channel into the logic-cell configuration sequencer shadow table.
interface lc_cfg_sequencer_if #(
  parameter int NUM_CELLS = 8
);
  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_idx;
  logic [20:0]      wr_cbit;
  logic             wr_err;

  modport master (
    output wr_valid, wr_idx, wr_cbit,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_idx, wr_cbit,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/lc_cfg_sequencer.sv
// Logic-cell config controller: shadow cbit table, freeze, serial shift-out, latch, release.
module lc_cfg_sequencer #(
  parameter int NUM_CELLS      = 8,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  lc_cfg_sequencer_if.slave wr,
  input  logic              commit,
  output logic              busy,
  output logic              done,
  output logic              cfg_prog,
  output logic              cfg_sen,
  output logic              cfg_sdo,
  output logic              cfg_latch,
  output logic              lc_ce_gate,
  output logic              lc_sr_force
);
  localparam int IDX_W   = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int FRAME_W = NUM_CELLS * 21;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int REL_W   = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FRAME_W - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W + 1)'(NUM_CELLS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PROG    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REL_W-1:0]   rel_q, rel_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] flat;
  logic               configured_q, configured_d;
  logic [20:0]        tbl_q [NUM_CELLS];

  logic wr_ready_q, wr_err_q, busy_q, done_q, prog_q, sen_q, sdo_q, latch_q, ce_q, sr_q;
  logic wr_err_d, busy_d, done_d, sen_d, sdo_d, latch_d, ce_d;

  logic accept, idx_ok;

  assign accept = wr.wr_valid && wr_ready_q;
  assign idx_ok = ({1'b0, wr.wr_idx} < IDX_LIM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_CELLS; i++) tbl_q[i] <= '0;
    end else if (accept && idx_ok) begin
      tbl_q[wr.wr_idx] <= wr.wr_cbit;
    end
  end

  // Cell NUM_CELLS-1 lands in the top bits so the frame shifts out MSB-first.
  always_comb begin
    flat = '0;
    for (int unsigned c = 0; c < NUM_CELLS; c++) flat[c*21 +: 21] = tbl_q[c];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rel_d        = rel_q;
    frame_d      = frame_q;
    configured_d = configured_q;
    sdo_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit) state_d = S_PROG;
      end
      S_PROG: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
        sdo_d   = flat[FRAME_W-1];
        frame_d = {flat[FRAME_W-2:0], 1'b0};
      end
      S_SHIFT: begin
        if (cnt_q == CNT_TERM) begin
          state_d = S_LATCH;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          sdo_d   = frame_q[FRAME_W-1];
          frame_d = {frame_q[FRAME_W-2:0], 1'b0};
        end
      end
      S_LATCH: begin
        state_d = S_RELEASE;
        rel_d   = '0;
      end
      S_RELEASE: begin
        if (rel_q == REL_LAST) begin
          state_d      = S_IDLE;
          configured_d = 1'b1;
        end else begin
          rel_d = rel_q + REL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with its state.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_RELEASE) && (state_d == S_IDLE);
    sen_d    = (state_d == S_SHIFT);
    latch_d  = (state_d == S_LATCH);
    ce_d     = (state_d == S_IDLE) && configured_d;
    wr_err_d = accept && !idx_ok;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rel_q        <= '0;
      frame_q      <= '0;
      configured_q <= 1'b0;
      wr_ready_q   <= 1'b1;
      wr_err_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      prog_q       <= 1'b0;
      sen_q        <= 1'b0;
      sdo_q        <= 1'b0;
      latch_q      <= 1'b0;
      ce_q         <= 1'b0;
      sr_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rel_q        <= rel_d;
      frame_q      <= frame_d;
      configured_q <= configured_d;
      wr_ready_q   <= !busy_d;
      wr_err_q     <= wr_err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      prog_q       <= busy_d;
      sen_q        <= sen_d;
      sdo_q        <= sdo_d;
      latch_q      <= latch_d;
      ce_q         <= ce_d;
      sr_q         <= !ce_d;
    end
  end

  assign wr.wr_ready = wr_ready_q;
  assign wr.wr_err   = wr_err_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_prog    = prog_q;
  assign cfg_sen     = sen_q;
  assign cfg_sdo     = sdo_q;
  assign cfg_latch   = latch_q;
  assign lc_ce_gate  = ce_q;
  assign lc_sr_force = sr_q;
endmodule

// File: tb/tb_lc_cfg_sequencer.sv
// Scoreboard bench: an 8-cell instance for the main flows, a 6-cell one for out-of-range writes.
module tb_lc_cfg_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, sel, h_valid, h_commit;
  logic [2:0]  h_idx;
  logic [20:0] h_cbit;

  // {ready, err, busy, done, prog, sen, sdo, latch, ce, sr}
  logic [9:0] a_o, b_o, o;
  localparam logic [9:0] RST_VAL = 10'b10_0000_0001;

  lc_cfg_sequencer_if #(.NUM_CELLS(8)) if_a ();
  lc_cfg_sequencer_if #(.NUM_CELLS(6)) if_b ();

  assign if_a.wr_valid = h_valid && !sel;
  assign if_a.wr_idx   = h_idx;
  assign if_a.wr_cbit  = h_cbit;
  assign if_b.wr_valid = h_valid && sel;
  assign if_b.wr_idx   = h_idx;
  assign if_b.wr_cbit  = h_cbit;
  assign a_o[9] = if_a.wr_ready;
  assign a_o[8] = if_a.wr_err;
  assign b_o[9] = if_b.wr_ready;
  assign b_o[8] = if_b.wr_err;

  lc_cfg_sequencer #(.NUM_CELLS(8), .RELEASE_CYCLES(2)) dut_a (
    .clk(clk), .resetn(resetn), .wr(if_a), .commit(h_commit && !sel),
    .busy(a_o[7]), .done(a_o[6]), .cfg_prog(a_o[5]), .cfg_sen(a_o[4]), .cfg_sdo(a_o[3]),
    .cfg_latch(a_o[2]), .lc_ce_gate(a_o[1]), .lc_sr_force(a_o[0])
  );

  lc_cfg_sequencer #(.NUM_CELLS(6), .RELEASE_CYCLES(1)) dut_b (
    .clk(clk), .resetn(resetn), .wr(if_b), .commit(h_commit && sel),
    .busy(b_o[7]), .done(b_o[6]), .cfg_prog(b_o[5]), .cfg_sen(b_o[4]), .cfg_sdo(b_o[3]),
    .cfg_latch(b_o[2]), .lc_ce_gate(b_o[1]), .lc_sr_force(b_o[0])
  );

  assign o = sel ? b_o : a_o;
  logic o_ready, o_err, o_busy, o_done, o_prog, o_sen, o_sdo, o_latch, o_ce, o_sr;
  assign {o_ready, o_err, o_busy, o_done, o_prog, o_sen, o_sdo, o_latch, o_ce, o_sr} = o;

  logic [20:0] m_a [8];
  logic [20:0] m_b [8];
  bit          sb_q [$];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ncells();
    return sel ? 6 : 8;
  endfunction

  task automatic model_write(input logic [2:0] idx, input logic [20:0] cbit);
    if (int'(idx) < ncells()) begin
      if (sel) m_b[idx] = cbit;
      else     m_a[idx] = cbit;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
  endtask

  task automatic push_frame();
    logic [20:0] w;
    for (int c = ncells() - 1; c >= 0; c--) begin
      w = sel ? m_b[c] : m_a[c];
      for (int b = 20; b >= 0; b--) sb_q.push_back(w[b]);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [20:0] cbit, input int hold);
    @(negedge clk);
    chk("wr_ready_idle", o_ready, 1);
    h_valid = 1'b1;
    h_idx   = idx;
    h_cbit  = cbit;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      model_write(idx, cbit);
      chk("wr_err", o_err, (int'(idx) >= ncells()) ? 1 : 0);
    end
    h_valid = 1'b0;
    @(negedge clk);
    chk("wr_err_clear", o_err, 0);
  endtask

  task automatic run_commit(input bit wr_too, input logic [2:0] idx, input logic [20:0] cbit,
                            input int abort_bit, input bit interfere);
    int cyc, sen_cnt, prog_cnt, latch_cnt, done_cyc, extra_done, extra_busy, fw, rc;
    bit exp;
    fw = ncells() * 21;
    rc = sel ? 1 : 2;
    cyc = 0; sen_cnt = 0; prog_cnt = 0; latch_cnt = 0; done_cyc = 0;
    @(negedge clk);
    chk("commit_ready", o_ready, 1);
    h_commit = 1'b1;
    if (wr_too) begin
      h_valid = 1'b1; h_idx = idx; h_cbit = cbit;
      model_write(idx, cbit);
    end
    sb_q.delete();
    push_frame();
    while (done_cyc == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin h_commit = 1'b0; h_valid = 1'b0; end
      if (o_prog) prog_cnt++;
      if (o_busy) chk("frozen", {o_ce, o_sr}, 2'b01);
      if (o_latch) begin
        latch_cnt++;
        chk("latch_sen_sdo", {o_sen, o_sdo}, 2'b00);
      end
      if (o_sen) begin
        sen_cnt++;
        if (sb_q.size() == 0) chk("sb_extra_bit", 1, 0);
        else begin
          exp = sb_q.pop_front();
          chk("sdo_bit", o_sdo, exp);
        end
      end
      if (interfere && cyc == 40) begin
        chk("ready_in_shift", o_ready, 0);
        h_commit = 1'b1; h_valid = 1'b1; h_idx = idx; h_cbit = cbit;
      end
      if (interfere && cyc == 41) h_commit = 1'b0;
      if (abort_bit > 0 && sen_cnt == abort_bit) begin
        #2 resetn = 1'b0;
        #1 chk("async_reset_outs", o, RST_VAL);
        repeat (5) begin
          @(negedge clk);
          if (o_latch) latch_cnt++;
          chk("held_reset_outs", o, RST_VAL);
        end
        chk("no_latch_on_abort", latch_cnt, 0);
        model_clear();
        sb_q.delete();
        resetn = 1'b1;
        return;
      end
      if (o_done) done_cyc = cyc;
    end
    chk("done_cycle", done_cyc, fw + 3 + rc);
    chk("sen_cycles", sen_cnt, fw);
    chk("prog_cycles", prog_cnt, fw + 2 + rc);
    chk("latch_pulses", latch_cnt, 1);
    chk("sb_left", sb_q.size(), 0);
    chk("released", {o_busy, o_ce, o_sr}, 3'b010);
    if (interfere) begin
      chk("ready_at_done", o_ready, 1);
      model_write(idx, cbit);
      @(negedge clk);
      h_valid = 1'b0;
      chk("late_write_err", o_err, 0);
    end
    extra_done = 0; extra_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_done) extra_done++;
      if (o_busy) extra_busy++;
    end
    chk("no_restart", {extra_done[15:0], extra_busy[15:0]}, 0);
  endtask

  initial begin
    resetn = 1'b0; sel = 1'b0; h_valid = 1'b0; h_commit = 1'b0; h_idx = '0; h_cbit = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_a_low", a_o, RST_VAL);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_a", a_o, RST_VAL);
    chk("reset_b", b_o, RST_VAL);

    wr(3'd0, 21'h1ABCDE, 1);
    wr(3'd7, 21'h000001, 1);
    run_commit(1'b0, 3'd0, 21'h0, 0, 1'b0);

    run_commit(1'b0, 3'd2, 21'h0ABCD, 0, 1'b1);

    run_commit(1'b1, 3'd3, 21'h155555, 0, 1'b0);

    run_commit(1'b0, 3'd0, 21'h0, 50, 1'b0);
    repeat (2) @(negedge clk);
    chk("after_abort_idle", a_o, RST_VAL);
    run_commit(1'b0, 3'd0, 21'h0, 0, 1'b0);

    sel = 1'b1;
    wr(3'd2, 21'h12345, 1);
    wr(3'd5, 21'h1C0003, 1);
    run_commit(1'b0, 3'd0, 21'h0, 0, 1'b0);
    wr(3'd7, 21'h1FFFFF, 3);
    wr(3'd6, 21'h0F0F0F, 1);
    run_commit(1'b0, 3'd0, 21'h0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
